// File: rtl/xge_tx_xgmii_framer.sv
// Framer for 10GbE transmit: pops packet words from a FWFT FIFO and emits XGMII words
// with start, terminate, error and idle control characters, plus per-frame status pulses.
module xge_tx_xgmii_framer #(
   parameter int MIN_LEN   = 64,
   parameter int MAX_LEN   = 1518,
   parameter int IPG_WORDS = 1
) (
   input  logic        clk_156,
   input  logic        rst_156,
   input  logic        tx_enable,
   input  logic [63:0] fifo_rdata,
   input  logic        fifo_rsop,
   input  logic        fifo_reop,
   input  logic [2:0]  fifo_rmod,
   input  logic        fifo_empty,
   output logic        fifo_read,
   output logic [63:0] xgmii_txd,
   output logic [7:0]  xgmii_txc,
   output logic        pkt_done,
   output logic [15:0] pkt_len,
   output logic [15:0] etherType,
   output logic        err_underflow,
   output logic        err_oversize,
   output logic        err_undersize,
   output logic        err_sop,
   output logic [2:0]  state_dbg
);

   localparam logic [63:0] IDLE_W  = 64'h0707070707070707;
   localparam logic [63:0] START_W = 64'hD5555555555555FB;
   localparam logic [63:0] ERR_W   = 64'hFEFEFEFEFEFEFEFE;
   localparam logic [63:0] TERM_W  = 64'h07070707070707FD;

   typedef enum logic [2:0] {
      S_IDLE, S_PREAMBLE, S_DATA, S_TERM, S_IPG, S_DRAIN
   } state_t;

   state_t      state, nxt_state;
   logic [15:0] byte_cnt, nxt_cnt;
   logic [1:0]  word_idx, nxt_widx;
   logic [3:0]  ipg_cnt, nxt_ipg;
   logic [63:0] nxt_txd;
   logic [7:0]  nxt_txc;
   logic        nxt_done, nxt_under, nxt_over, nxt_unds, nxt_sop;
   logic [15:0] nxt_len, nxt_et;
   logic        rd;
   logic [3:0]  add;
   logic [16:0] sum;
   logic [15:0] new_cnt;

   assign state_dbg = state;
   assign fifo_read = rd && !rst_156;

   // Bytes contributed by the head word; the count saturates rather than wrapping.
   assign add     = (fifo_reop && fifo_rmod != 3'd0) ? {1'b0, fifo_rmod} : 4'd8;
   assign sum     = {1'b0, byte_cnt} + {13'd0, add};
   assign new_cnt = sum[16] ? 16'hFFFF : sum[15:0];

   always_comb begin
      nxt_state = state;
      nxt_cnt   = byte_cnt;
      nxt_widx  = word_idx;
      nxt_ipg   = ipg_cnt;
      nxt_txd   = IDLE_W;
      nxt_txc   = 8'hFF;
      nxt_done  = 1'b0;
      nxt_under = 1'b0;
      nxt_over  = 1'b0;
      nxt_unds  = 1'b0;
      nxt_sop   = 1'b0;
      nxt_len   = pkt_len;
      nxt_et    = etherType;
      rd        = 1'b0;
      case (state)
         S_IDLE: begin
            if (!fifo_empty) begin
               if (!fifo_rsop) begin
                  rd      = 1'b1;
                  nxt_sop = 1'b1;
               end else if (tx_enable) begin
                  nxt_state = S_PREAMBLE;
               end
            end
         end
         S_PREAMBLE: begin
            nxt_txd   = START_W;
            nxt_txc   = 8'h01;
            nxt_cnt   = 16'd0;
            nxt_widx  = 2'd0;
            nxt_state = S_DATA;
         end
         S_DATA: begin
            if (fifo_empty) begin
               nxt_txd   = ERR_W;
               nxt_done  = 1'b1;
               nxt_under = 1'b1;
               nxt_len   = byte_cnt;
               nxt_ipg   = 4'd0;
               nxt_state = S_IPG;
            end else begin
               rd      = 1'b1;
               nxt_cnt = new_cnt;
               if (word_idx == 2'd1) nxt_et = {fifo_rdata[39:32], fifo_rdata[47:40]};
               if (word_idx != 2'd2) nxt_widx = word_idx + 2'd1;
               if (new_cnt > 16'(MAX_LEN)) begin
                  nxt_txd   = ERR_W;
                  nxt_done  = 1'b1;
                  nxt_over  = 1'b1;
                  nxt_len   = new_cnt;
                  nxt_ipg   = 4'd0;
                  nxt_state = fifo_reop ? S_IPG : S_DRAIN;
               end else if (!fifo_reop || fifo_rmod == 3'd0) begin
                  nxt_txd = fifo_rdata;
                  nxt_txc = 8'h00;
                  if (fifo_reop) nxt_state = S_TERM;
               end else begin
                  // Partial last word: terminate lands in lane rmod, idles above it.
                  for (int i = 0; i < 8; i++) begin
                     if (i < int'(fifo_rmod)) begin
                        nxt_txd[i*8 +: 8] = fifo_rdata[i*8 +: 8];
                        nxt_txc[i]        = 1'b0;
                     end else if (i == int'(fifo_rmod)) begin
                        nxt_txd[i*8 +: 8] = 8'hFD;
                     end
                  end
                  nxt_done  = 1'b1;
                  nxt_len   = new_cnt;
                  nxt_unds  = new_cnt < 16'(MIN_LEN);
                  nxt_ipg   = 4'd0;
                  nxt_state = S_IPG;
               end
            end
         end
         S_TERM: begin
            nxt_txd   = TERM_W;
            nxt_done  = 1'b1;
            nxt_len   = byte_cnt;
            nxt_unds  = byte_cnt < 16'(MIN_LEN);
            nxt_ipg   = 4'd0;
            nxt_state = S_IPG;
         end
         S_IPG: begin
            // On the last gap word a waiting SOP starts directly, so the gap is exactly IPG_WORDS.
            if (ipg_cnt == 4'(IPG_WORDS - 1)) begin
               if (!fifo_empty && fifo_rsop && tx_enable) nxt_state = S_PREAMBLE;
               else                                        nxt_state = S_IDLE;
            end else begin
               nxt_ipg = ipg_cnt + 4'd1;
            end
         end
         S_DRAIN: begin
            if (!fifo_empty) begin
               rd = 1'b1;
               if (fifo_reop) begin
                  nxt_ipg   = 4'd0;
                  nxt_state = S_IPG;
               end
            end
         end
         default: nxt_state = S_IDLE;
      endcase
   end

   always_ff @(posedge clk_156) begin
      if (rst_156) begin
         state         <= S_IDLE;
         byte_cnt      <= 16'd0;
         word_idx      <= 2'd0;
         ipg_cnt       <= 4'd0;
         xgmii_txd     <= IDLE_W;
         xgmii_txc     <= 8'hFF;
         pkt_done      <= 1'b0;
         err_underflow <= 1'b0;
         err_oversize  <= 1'b0;
         err_undersize <= 1'b0;
         err_sop       <= 1'b0;
         pkt_len       <= 16'd0;
         etherType     <= 16'd0;
      end else begin
         state         <= nxt_state;
         byte_cnt      <= nxt_cnt;
         word_idx      <= nxt_widx;
         ipg_cnt       <= nxt_ipg;
         xgmii_txd     <= nxt_txd;
         xgmii_txc     <= nxt_txc;
         pkt_done      <= nxt_done;
         err_underflow <= nxt_under;
         err_oversize  <= nxt_over;
         err_undersize <= nxt_unds;
         err_sop       <= nxt_sop;
         pkt_len       <= nxt_len;
         etherType     <= nxt_et;
      end
   end

endmodule

// File: tb/tb_xge_tx_xgmii_framer.sv
// Bench for xge_tx_xgmii_framer: a FWFT FIFO model feeds directed packets, a monitor
// checks every non-idle XGMII word and status pulse against an expected queue.
module tb_xge_tx_xgmii_framer;

   localparam logic [63:0] IDLE_W  = 64'h0707070707070707;
   localparam logic [63:0] START_W = 64'hD5555555555555FB;
   localparam logic [63:0] ERR_W   = 64'hFEFEFEFEFEFEFEFE;
   localparam logic [63:0] TERM_W  = 64'h07070707070707FD;
   localparam int          IPG_WORDS = 1;

   logic        clk_156 = 1'b0;
   logic        rst_156 = 1'b1;
   logic        tx_enable = 1'b1;
   logic [63:0] fifo_rdata = '0;
   logic        fifo_rsop = 1'b0, fifo_reop = 1'b0, fifo_empty = 1'b1;
   logic [2:0]  fifo_rmod = '0;
   logic        fifo_read, pkt_done, err_underflow, err_oversize, err_undersize, err_sop;
   logic [63:0] xgmii_txd;
   logic [7:0]  xgmii_txc;
   logic [15:0] pkt_len, etherType;
   logic [2:0]  state_dbg;

   xge_tx_xgmii_framer #(.MIN_LEN(64), .MAX_LEN(1518), .IPG_WORDS(IPG_WORDS)) dut (
      .clk_156(clk_156), .rst_156(rst_156), .tx_enable(tx_enable),
      .fifo_rdata(fifo_rdata), .fifo_rsop(fifo_rsop), .fifo_reop(fifo_reop),
      .fifo_rmod(fifo_rmod), .fifo_empty(fifo_empty), .fifo_read(fifo_read),
      .xgmii_txd(xgmii_txd), .xgmii_txc(xgmii_txc), .pkt_done(pkt_done),
      .pkt_len(pkt_len), .etherType(etherType), .err_underflow(err_underflow),
      .err_oversize(err_oversize), .err_undersize(err_undersize), .err_sop(err_sop),
      .state_dbg(state_dbg)
   );

   always #5 clk_156 = ~clk_156;

   // {data, sop, eop, mod}
   logic [68:0]  fifo_q[$];
   // {txd, txc, done, under, over, unds, sop, pkt_len, etherType}
   logic [108:0] exp_q[$];
   int           gap_q[$];
   int           total = 0, bad = 0;
   logic [15:0]  exp_et = 16'd0;
   bit           do_pop, mon_en = 1'b0, have_end = 1'b0;
   int           gap_cnt = 0, gap_exp;
   logic [108:0] e;
   logic [76:0]  a;

   task automatic refresh();
      if (fifo_q.size() == 0) begin
         fifo_empty = 1'b1;
         {fifo_rdata, fifo_rsop, fifo_reop, fifo_rmod} = '0;
      end else begin
         fifo_empty = 1'b0;
         {fifo_rdata, fifo_rsop, fifo_reop, fifo_rmod} = fifo_q[0];
      end
   endtask

   // FIFO model: pop on the strobe seen at the edge, present the new head shortly after.
   always @(posedge clk_156) begin
      do_pop = fifo_read;
      #1;
      if (do_pop) begin
         total++;
         if (fifo_q.size() == 0) begin
            bad++;
            $display("FAIL read_empty: fifo_read=1 with fifo_empty=1");
         end else begin
            void'(fifo_q.pop_front());
         end
      end
      refresh();
   end

   // Monitor: every non-idle word or any status pulse must match the head of exp_q.
   always @(negedge clk_156) begin
      if (mon_en) begin
         a = {xgmii_txd, xgmii_txc, pkt_done, err_underflow, err_oversize, err_undersize, err_sop};
         if (rst_156) have_end = 1'b0;
         if (xgmii_txd != IDLE_W || xgmii_txc != 8'hFF || a[4:0] != 5'd0) begin
            total++;
            if (exp_q.size() == 0) begin
               bad++;
               $display("FAIL unexpected_word: got %h/%h flags %b, want nothing", xgmii_txd, xgmii_txc, a[4:0]);
            end else begin
               e = exp_q.pop_front();
               if (a !== e[108:32]) begin
                  bad++;
                  $display("FAIL word: got %h/%h flags %b, want %h/%h flags %b",
                           xgmii_txd, xgmii_txc, a[4:0], e[108:45], e[44:37], e[36:32]);
               end
               if (e[36]) begin
                  total++;
                  if ({pkt_len, etherType} !== e[31:0]) begin
                     bad++;
                     $display("FAIL len_type: got len=%0d type=%h, want len=%0d type=%h",
                              pkt_len, etherType, e[31:16], e[15:0]);
                  end
               end
            end
            if (xgmii_txd == START_W && xgmii_txc == 8'h01) begin
               gap_exp = (gap_q.size() != 0) ? gap_q.pop_front() : -1;
               if (have_end) begin
                  total++;
                  if (gap_cnt < IPG_WORDS || (gap_exp >= 0 && gap_cnt != gap_exp)) begin
                     bad++;
                     $display("FAIL ipg: got %0d idle words, want %0d (min %0d)", gap_cnt, gap_exp, IPG_WORDS);
                  end
               end
            end
         end
         if (xgmii_txd == IDLE_W && xgmii_txc == 8'hFF) gap_cnt++;
         if (pkt_done) begin
            have_end = 1'b1;
            gap_cnt  = 0;
         end
      end
   end

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h want %h", name, act, exp);
      end
   endtask

   task automatic exp_push(input logic [63:0] d, input logic [7:0] c, input logic [4:0] fl,
                           input logic [15:0] len, input logic [15:0] et);
      exp_q.push_back({d, c, fl, len, et});
   endtask

   function automatic logic [63:0] make_word(input int k, input logic [15:0] et);
      logic [63:0] w;
      for (int j = 0; j < 8; j++) begin
         if (k * 8 + j == 12)      w[j*8 +: 8] = et[15:8];
         else if (k * 8 + j == 13) w[j*8 +: 8] = et[7:0];
         else                      w[j*8 +: 8] = 8'((k * 8 + j) * 7 + 3);
      end
      return w;
   endfunction

   // Legal-size packet: queue the FIFO words and the hand-built XGMII sequence.
   task automatic send_pkt(input int len, input logic [15:0] et, input int gap);
      int          nw, r;
      logic [63:0] w, tw;
      logic [7:0]  tc;
      nw = (len + 7) / 8;
      r  = len % 8;
      gap_q.push_back(gap);
      exp_push(START_W, 8'h01, 5'b0, 16'd0, 16'd0);
      if (nw >= 2) exp_et = et;
      for (int k = 0; k < nw; k++) begin
         w = make_word(k, et);
         fifo_q.push_back({w, k == 0, k == nw - 1, (k == nw - 1) ? 3'(r) : 3'd0});
         if (k < nw - 1) begin
            exp_push(w, 8'h00, 5'b0, 16'd0, 16'd0);
         end else if (r == 0) begin
            exp_push(w, 8'h00, 5'b0, 16'd0, 16'd0);
            exp_push(TERM_W, 8'hFF, {1'b1, 2'b00, len < 64, 1'b0}, 16'(len), exp_et);
         end else begin
            for (int j = 0; j < 8; j++) begin
               tw[j*8 +: 8] = (j < r) ? w[j*8 +: 8] : (j == r) ? 8'hFD : 8'h07;
               tc[j]        = (j >= r);
            end
            exp_push(tw, tc, {1'b1, 2'b00, len < 64, 1'b0}, 16'(len), exp_et);
         end
      end
      refresh();
   endtask

   task automatic wait_drain(input string name);
      int n = 0;
      while ((exp_q.size() != 0 || fifo_q.size() != 0) && n < 400) begin
         @(posedge clk_156);
         #2;
         n++;
      end
      total++;
      if (n >= 400) begin
         bad++;
         $display("FAIL %s_timeout: %0d words still expected after %0d cycles", name, exp_q.size(), n);
      end
      repeat (4) @(posedge clk_156);
      #2;
   endtask

   initial begin
      refresh();
      repeat (3) @(posedge clk_156);
      #2;
      mon_en = 1'b1;
      check("rst_txd", xgmii_txd, IDLE_W);
      check("rst_txc", 64'(xgmii_txc), 64'hFF);
      check("rst_len_type", {32'd0, pkt_len, etherType}, 64'd0);
      check("rst_pulses", 64'({pkt_done, err_underflow, err_oversize, err_undersize, err_sop, fifo_read}), 64'd0);
      rst_156 = 1'b0;

      // Held by tx_enable, then a 64-byte frame followed back-to-back by a 65-byte frame.
      tx_enable = 1'b0;
      send_pkt(64, 16'h0800, -1);
      repeat (10) @(posedge clk_156);
      #2;
      check("hold_fifo", 64'(fifo_q.size()), 64'd8);
      check("hold_exp", 64'(exp_q.size()), 64'd10);
      tx_enable = 1'b1;
      send_pkt(65, 16'h0800, IPG_WORDS);
      wait_drain("b2b");
      check("et_0800", 64'(etherType), 64'h0800);

      send_pkt(60, 16'h86DD, -1);
      wait_drain("under60");

      // Three data words then the FIFO runs dry.
      gap_q.push_back(-1);
      exp_push(START_W, 8'h01, 5'b0, 16'd0, 16'd0);
      exp_et = 16'h88CC;
      for (int k = 0; k < 3; k++) begin
         fifo_q.push_back({make_word(k, 16'h88CC), k == 0, 1'b0, 3'd0});
         exp_push(make_word(k, 16'h88CC), 8'h00, 5'b0, 16'd0, 16'd0);
      end
      exp_push(ERR_W, 8'hFF, 5'b11000, 16'd24, 16'h88CC);
      refresh();
      wait_drain("underflow");

      // Stray non-SOP word while idle.
      fifo_q.push_back({64'h1122334455667788, 1'b0, 1'b1, 3'd0});
      exp_push(IDLE_W, 8'hFF, 5'b00001, 16'd0, 16'd0);
      refresh();
      wait_drain("err_sop");

      // 1526-byte frame: aborted on the word that takes the count to 1520, rest drained.
      gap_q.push_back(-1);
      exp_push(START_W, 8'h01, 5'b0, 16'd0, 16'd0);
      exp_et = 16'h0806;
      for (int k = 0; k < 191; k++) begin
         fifo_q.push_back({make_word(k, 16'h0806), k == 0, k == 190, (k == 190) ? 3'd6 : 3'd0});
         if (k < 189) exp_push(make_word(k, 16'h0806), 8'h00, 5'b0, 16'd0, 16'd0);
      end
      exp_push(ERR_W, 8'hFF, 5'b10100, 16'd1520, 16'h0806);
      refresh();
      send_pkt(64, 16'h0800, -1);
      wait_drain("oversize");

      // Reset in the middle of a frame: START and four data words reach the line, then idle.
      gap_q.push_back(-1);
      exp_push(START_W, 8'h01, 5'b0, 16'd0, 16'd0);
      for (int k = 0; k < 8; k++) begin
         fifo_q.push_back({make_word(k, 16'h0842), k == 0, k == 7, 3'd0});
         if (k < 4) exp_push(make_word(k, 16'h0842), 8'h00, 5'b0, 16'd0, 16'd0);
      end
      refresh();
      for (int n = 0; n < 50 && exp_q.size() > 1; n++) begin
         @(posedge clk_156);
         #2;
      end
      check("rst_sync", 64'(exp_q.size()), 64'd1);
      rst_156 = 1'b1;
      fifo_q.delete();
      refresh();
      @(posedge clk_156);
      #2;
      check("midrst_txd", xgmii_txd, IDLE_W);
      check("midrst_txc", 64'(xgmii_txc), 64'hFF);
      check("midrst_len_type", {32'd0, pkt_len, etherType}, 64'd0);
      check("midrst_pulses", 64'({pkt_done, err_underflow, err_oversize, err_undersize, fifo_read}), 64'd0);
      rst_156 = 1'b0;
      exp_et  = 16'd0;
      repeat (3) @(posedge clk_156);
      #2;
      check("midrst_flush", 64'(exp_q.size()), 64'd0);

      send_pkt(65, 16'h0800, -1);
      wait_drain("recover");
      check("final_exp_empty", 64'(exp_q.size()), 64'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
